// File: rtl/fsm_cmd_responder.sv
// Command-code responder: mirrors the read/write sequencer state, checks each
// transition and executes legal reads/writes against a small register file.
module fsm_cmd_responder #(
  parameter int DW = 8,
  parameter int AW = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    cmd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          wack,
  output logic          err,
  output logic [2:0]    mstate,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] wr_cnt
);

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_RD1  = 3'b011;
  localparam logic [2:0] C_RD2  = 3'b100;
  localparam logic [2:0] C_WR1  = 3'b001;
  localparam logic [2:0] C_WR2  = 3'b010;

  // Mirror states share the command encoding so mstate can be exported directly.
  typedef enum logic [2:0] {
    M_IDLE = 3'b000,
    M_RD1  = 3'b011,
    M_RD2  = 3'b100,
    M_WR1  = 3'b001,
    M_WR2  = 3'b010
  } state_t;

  state_t        state;
  logic [AW-1:0] a_q;
  logic [DW-1:0] mem [2**AW];

  assign mstate = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= M_IDLE;
      a_q    <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      wack   <= 1'b0;
      err    <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else begin
      rvalid <= 1'b0;
      wack   <= 1'b0;
      err    <= 1'b0;
      case (state)
        M_IDLE: begin
          if (cmd == C_IDLE) begin
            state <= M_IDLE;
          end else if (cmd == C_RD1) begin
            state <= M_RD1;
            a_q   <= addr;
          end else if (cmd == C_WR1) begin
            state <= M_WR1;
            a_q   <= addr;
          end else begin
            state <= M_IDLE;
            err   <= 1'b1;
          end
        end
        M_RD1: begin
          if (cmd == C_RD2) begin
            state  <= M_RD2;
            rdata  <= mem[a_q];
            rvalid <= 1'b1;
            rd_cnt <= rd_cnt + CW'(1);
          end else if (cmd == C_WR2) begin
            // read aborted into a write to the already latched address
            state    <= M_WR2;
            mem[a_q] <= wdata;
            wack     <= 1'b1;
            wr_cnt   <= wr_cnt + CW'(1);
          end else begin
            state <= M_IDLE;
            err   <= 1'b1;
          end
        end
        M_RD2: begin
          if (cmd == C_IDLE) begin
            state <= M_IDLE;
          end else if (cmd == C_WR1) begin
            state <= M_WR1;
            a_q   <= addr;
          end else begin
            state <= M_IDLE;
            err   <= 1'b1;
          end
        end
        M_WR1: begin
          if (cmd == C_WR2) begin
            state    <= M_WR2;
            mem[a_q] <= wdata;
            wack     <= 1'b1;
            wr_cnt   <= wr_cnt + CW'(1);
          end else begin
            state <= M_IDLE;
            err   <= 1'b1;
          end
        end
        M_WR2: begin
          if (cmd == C_IDLE) begin
            state <= M_IDLE;
          end else begin
            state <= M_IDLE;
            err   <= 1'b1;
          end
        end
        default: begin
          state <= M_IDLE;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_cmd_responder.sv
// Self-checking bench for fsm_cmd_responder: directed scenarios plus random
// command streams compared against a transition-table reference model.
module tb_fsm_cmd_responder;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    cmd = 3'b000;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid, wack, err;
  logic [2:0]    mstate;
  logic [CW-1:0] rd_cnt, wr_cnt;

  int errors = 0;
  int checks = 0;

  // reference model
  logic [DW-1:0] m_mem [2**AW];
  logic [2:0]    m_st;
  logic [AW-1:0] m_aq;
  logic [DW-1:0] m_rdata;
  logic          m_rv, m_wk, m_er;
  logic [CW-1:0] m_rc, m_wc;

  fsm_cmd_responder #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .wack(wack), .err(err),
    .mstate(mstate), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Legal (previous accepted code, new code) pairs as octal digit pairs.
  function automatic bit legal(input logic [2:0] p, input logic [2:0] c);
    case ({p, c})
      6'o00, 6'o03, 6'o01, 6'o34, 6'o32, 6'o40, 6'o41, 6'o12, 6'o20: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    m_st = 3'b000; m_aq = '0; m_rdata = '0;
    m_rv = 0; m_wk = 0; m_er = 0; m_rc = '0; m_wc = '0;
  endtask

  task automatic model_edge(input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_rv = 0; m_wk = 0; m_er = 0;
    if (!legal(m_st, c)) begin
      m_er = 1; m_st = 3'b000;
    end else begin
      m_st = c;
      if (c == 3'b011 || c == 3'b001) m_aq = a;
      if (c == 3'b100) begin m_rdata = m_mem[m_aq]; m_rv = 1; m_rc = m_rc + 1'b1; end
      if (c == 3'b010) begin m_mem[m_aq] = d; m_wk = 1; m_wc = m_wc + 1'b1; end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdata"},  32'(rdata),  32'(m_rdata));
    check({tag, ".rvalid"}, 32'(rvalid), 32'(m_rv));
    check({tag, ".wack"},   32'(wack),   32'(m_wk));
    check({tag, ".err"},    32'(err),    32'(m_er));
    check({tag, ".mstate"}, 32'(mstate), 32'(m_st));
    check({tag, ".rd_cnt"}, 32'(rd_cnt), 32'(m_rc));
    check({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(m_wc));
  endtask

  task automatic step(input string tag, input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rst = 0; cmd = c; addr = a; wdata = d;
    @(posedge clk);
    model_edge(c, a, d);
    #1 check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic [2:0] c);
    @(negedge clk);
    rst = 1; cmd = c; addr = '1; wdata = '1;
    @(posedge clk);
    model_reset();
    #1 check_all(tag);
  endtask

  initial begin
    logic [2:0] c;
    model_reset();
    do_reset("reset", 3'b000);
    check("reset.mstate_zero", 32'(mstate), 32'd0);

    // write then read
    step("wr1", 3'b001, 2'd2, 8'h00);
    step("wr2", 3'b010, 2'd0, 8'hA5);
    check("wr2.wack_pulse", 32'(wack), 32'd1);
    step("wr_idle", 3'b000, 2'd0, 8'h00);
    check("wr_idle.wack_low", 32'(wack), 32'd0);
    step("rd1", 3'b011, 2'd2, 8'h00);
    step("rd2", 3'b100, 2'd0, 8'h00);
    check("wt_rd.rdata", 32'(rdata), 32'hA5);
    check("wt_rd.rvalid", 32'(rvalid), 32'd1);
    check("wt_rd.counts", {16'(rd_cnt), 16'(wr_cnt)}, {16'd1, 16'd1});
    step("rd_idle", 3'b000, 2'd0, 8'h00);

    // read aborted into write
    step("ab_rd1", 3'b011, 2'd1, 8'h00);
    step("ab_wr2", 3'b010, 2'd0, 8'h3C);
    check("abort.rvalid_low", 32'(rvalid), 32'd0);
    check("abort.rd_cnt", 32'(rd_cnt), 32'd1);
    step("ab_idle", 3'b000, 2'd0, 8'h00);
    step("ab_chk1", 3'b011, 2'd1, 8'h00);
    step("ab_chk2", 3'b100, 2'd0, 8'h00);
    check("abort.mem1", 32'(rdata), 32'h3C);

    // chained read then write at addr 3
    step("ch_rd2_idle", 3'b000, 2'd0, 8'h00);
    step("ch_rd1", 3'b011, 2'd3, 8'h00);
    step("ch_rd2", 3'b100, 2'd3, 8'h00);
    step("ch_wr1", 3'b001, 2'd3, 8'h00);
    step("ch_wr2", 3'b010, 2'd3, 8'h5A);
    step("ch_idle", 3'b000, 2'd3, 8'h00);
    check("chain.mstate", 32'(mstate), 32'd0);

    // illegal transitions
    step("ill_rd2", 3'b100, 2'd0, 8'h00);
    check("ill_rd2.err", 32'(err), 32'd1);
    step("ill_rec", 3'b001, 2'd0, 8'h00);
    step("ill_111", 3'b111, 2'd0, 8'hFF);
    check("ill_111.err", 32'(err), 32'd1);
    step("ill_rd1", 3'b011, 2'd0, 8'h00);
    step("ill_rd2b", 3'b100, 2'd0, 8'h00);
    check("ill_111.mem0", 32'(rdata), 32'h00);
    step("ill_idle", 3'b000, 2'd0, 8'h00);

    // reset mid-write, then WR_S2 after release is an error
    step("rw_wr1", 3'b001, 2'd2, 8'h00);
    do_reset("rw_rst", 3'b010);
    step("rw_wr2", 3'b010, 2'd2, 8'h77);
    check("rw_wr2.err", 32'(err), 32'd1);
    step("rw_rd1", 3'b011, 2'd2, 8'h00);
    step("rw_rd2", 3'b100, 2'd2, 8'h00);
    check("rw.mem2_cleared", 32'(rdata), 32'h00);
    step("rw_idle", 3'b000, 2'd0, 8'h00);

    // counter wrap
    do_reset("wrap_rst", 3'b000);
    for (int i = 0; i < 256; i++) begin
      step("wrap_rd1", 3'b011, AW'(i), 8'h00);
      step("wrap_rd2", 3'b100, 2'd0, 8'h00);
      step("wrap_idle", 3'b000, 2'd0, 8'h00);
    end
    check("wrap.rd_cnt", 32'(rd_cnt), 32'd0);
    check("wrap.wr_cnt", 32'(wr_cnt), 32'd0);

    // random command streams, biased toward legal sequences
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst", 3'($urandom_range(0, 7)));
      end else begin
        c = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) < 8) begin
          for (int t = 0; t < 64 && !legal(m_st, c); t++) c = 3'($urandom_range(0, 7));
        end
        step("rnd", c, AW'($urandom), DW'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_cmd_responder.md
# fsm_cmd_responder

Receiving end of the 3-bit command-code stream produced by the read/write sequencer FSM. It decodes each registered code, mirrors the sequencer's state, and checks every transition for legality. Legal read and write sequences are executed against a small internal register file. The block sits directly downstream of the sequencer's `out[2:0]` bus, flags protocol errors, and counts completed transactions.

## Interface
- `DW`, default 8: data width of register-file entries, `wdata` and `rdata`.
- `AW`, default 2: address width; register-file depth is 2^AW.
- `CW`, default 8: width of the `rd_cnt` and `wr_cnt` transaction counters.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd`  in  3  command code from the sequencer. Encoding:
  - 000 IDLE
  - 011 RD_S1
  - 100 RD_S2
  - 001 WR_S1
  - 010 WR_S2
  - 101/110/111 are never legal.
- `addr`  in  AW  transaction address; sampled on RD_S1 and WR_S1 accepts.
- `wdata`  in  DW  write data; sampled on WR_S2 accept.
- `rdata`  out  DW  read data; holds its last value between reads.
- `rvalid`  out  1  one-cycle pulse; `rdata` is updated this cycle.
- `wack`  out  1  one-cycle pulse; write committed.
- `err`  out  1  one-cycle pulse; illegal code or transition detected.
- `mstate`  out  3  mirrored sequencer state, reusing the `cmd` encoding.
- `rd_cnt`  out  CW  completed reads, wraps modulo 2^CW.
- `wr_cnt`  out  CW  completed writes, wraps modulo 2^CW.

## Operation
- Mirror FSM states: M_IDLE, M_RD1, M_RD2, M_WR1, M_WR2. On each edge, `cmd` is evaluated against the current `mstate`.
- Legal transitions and their actions:
  - M_IDLE + 000 → M_IDLE; no action.
  - M_IDLE + 011 → M_RD1; latch `addr` into `a_q`.
  - M_IDLE + 001 → M_WR1; latch `addr` into `a_q`.
  - M_RD1 + 100 → M_RD2; read: `rdata` ← mem[`a_q`], `rvalid`=1, `rd_cnt`+1.
  - M_RD1 + 010 → M_WR2; write-through abort of the read:
    - mem[`a_q`] ← `wdata`, `wack`=1, `wr_cnt`+1.
    - No read is performed and `rd_cnt` is unchanged.
  - M_RD2 + 000 → M_IDLE; no action.
  - M_RD2 + 001 → M_WR1; latch `addr` into `a_q`.
  - M_WR1 + 010 → M_WR2; mem[`a_q`] ← `wdata`, `wack`=1, `wr_cnt`+1.
  - M_WR2 + 000 → M_IDLE; no action.
- Any other (state, code) pair, including codes 101/110/111:
  - `err`=1 for that cycle, next `mstate` = M_IDLE.
  - No memory access, no counter change, `a_q` unchanged.
- Recovery is one cycle. A 011 or 001 arriving one cycle after the error is accepted normally from M_IDLE.
- The register file is written only on a WR_S2 accept. Reads never alter the memory.
- Counters wrap silently: `rd_cnt` increments only on the M_RD1→M_RD2 transition, `wr_cnt` on any accepted write.

## Timing
- All outputs are registered, with no combinational path from `cmd` to any output.
- Accept at edge N → `rvalid`/`wack`/`err` high during cycle N+1 only.
- `rdata` changes only at an edge that sets `rvalid`.
- `mstate` reflects the transition taken at edge N during cycle N+1.
- Read latency: `rdata` is valid one cycle after the RD_S2 code is sampled, i.e. two edges after RD_S1.
- A write is visible to a read in the following transaction. At most one memory access occurs per cycle, because RD2 and WR2 are exclusive.
- Back-to-back transactions (RD2→WR1, WR2→IDLE→RD1) need no idle gaps beyond those the sequence itself imposes.
- Reset behaviour (`rst`=1 at an edge) overrides everything:
  - `mstate`=M_IDLE, all mem entries=0, `rdata`=0.
  - `rvalid`=`wack`=`err`=0, `rd_cnt`=`wr_cnt`=0, `a_q`=0.
- Reset mid-transaction discards a pending write. A 100 or 010 arriving on the first cycle after reset releases is an error.

## Test plan
- Write then read: (`cmd`=001, `addr`=2) → (010, `wdata`=0xA5) → 000 → 011 (`addr`=2) → 100 → `wack` pulse, then `rvalid` with `rdata`=0xA5; `wr_cnt`=1, `rd_cnt`=1.
- Read-abort path: 011 (`addr`=1) → 010 (`wdata`=0x3C) → 000 → `wack`=1, mem[1]=0x3C, `rd_cnt`=0, no `rvalid`.
- Chained sequence: 011, 100, 001, 010, 000 with `addr`=3 → `rvalid` then `wack`, `mstate` ends at 000, no `err`.
- Illegal transitions:
  - 100 from M_IDLE → `err` pulse, `mstate`=000, counters unchanged.
  - 111 from M_WR1 → `err`, pending write dropped, mem unchanged.
- Reset mid-write: 001 then `rst`=1 on the next edge → mem all 0, outputs 0; a 010 after release → `err`.
- Counter wrap (CW=8): 256 complete reads → `rd_cnt`=0, `wr_cnt` unchanged, no `err`.
